// File: rtl/mb_clk_det_pkg.sv
// Shared types and default patterns for the multi-lane clock detector.
// Patterns are MSB-oldest, matching the capture shift order.
package mb_clk_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ALIGN   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } det_state_t;

    localparam logic [47:0] CKP_PAT = 48'hAAAAAAAA0000;
    localparam logic [47:0] CKN_PAT = 48'h555555550000;
    localparam logic [47:0] TRK_PAT = 48'hAAAAAAAA0000;

    function automatic logic is_busy(input det_state_t s);
        return (s == ST_ALIGN) || (s == ST_CAPTURE) ||
               (s == ST_COMPARE);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for one asynchronous line.
// Both flops clear on reset so the line reads 0 until re-sampled.
module bit_synchronizer (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/multi_lane_clock_detector.sv
// Aligns on a channel-0 zero run, then captures and compares
// fixed-width windows on every channel, counting matches.
module multi_lane_clock_detector
    import mb_clk_det_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int PAT_W         = 48,
    parameter int ZERO_RUN      = 8,
    parameter int MAX_ITER      = 16,
    parameter int REQ_MATCH     = 16,
    parameter int ALIGN_TIMEOUT = 1024
) (
    input  logic                    i_dig_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_ch,
    input  logic [NUM_CH*PAT_W-1:0] i_expected,
    input  logic                    i_start,
    input  logic                    i_clear_results,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [NUM_CH-1:0]       o_result_logged,
    output logic [NUM_CH*$clog2(MAX_ITER+1)-1:0] o_match_cnt
);

    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam int BIT_W = $clog2(PAT_W + 1);
    localparam int ZR_W  = $clog2(ZERO_RUN + 1);
    localparam int AT_W  = $clog2(ALIGN_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] REQ_CNT   = CNT_W'(REQ_MATCH);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MAX_ITER - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAT_W - 1);
    localparam logic [ZR_W-1:0]  ZR_LAST   = ZR_W'(ZERO_RUN - 1);
    localparam logic [AT_W-1:0]  AT_LAST   = AT_W'(ALIGN_TIMEOUT - 1);

    logic [NUM_CH-1:0] w_ch;

    det_state_t r_state;
    det_state_t w_next;
    logic       w_start_run;
    logic       w_aligned;
    logic       w_align_to;

    logic [ZR_W-1:0]  r_zero_cnt;
    logic [AT_W-1:0]  r_align_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_iter_cnt;
    logic [PAT_W-1:0] r_shift [NUM_CH];
    logic [CNT_W-1:0] r_match [NUM_CH];
    logic [NUM_CH-1:0] r_result;
    logic             r_timeout;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        bit_synchronizer u_sync (
            .i_clk   (i_dig_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_ch[g]),
            .o_q     (w_ch[g])
        );
        assign o_match_cnt[g*CNT_W +: CNT_W] = r_match[g];
    end

    always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Clear beats start; alignment beats timeout in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        w_aligned   = 1'b0;
        w_align_to  = 1'b0;
        if (i_clear_results) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_next      = ST_ALIGN;
                        w_start_run = 1'b1;
                    end
                end
                ST_ALIGN: begin
                    if (!w_ch[0] && r_zero_cnt == ZR_LAST) begin
                        w_next    = ST_CAPTURE;
                        w_aligned = 1'b1;
                    end else if (r_align_cnt == AT_LAST) begin
                        w_next     = ST_DONE;
                        w_align_to = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        w_next = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (r_iter_cnt == ITER_LAST) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_CAPTURE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero_cnt  <= '0;
            r_align_cnt <= '0;
            r_bit_cnt   <= '0;
            r_iter_cnt  <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shift[c] <= '0;
                r_match[c] <= '0;
            end
        end else if (i_clear_results) begin
            r_zero_cnt  <= '0;
            r_align_cnt <= '0;
            r_bit_cnt   <= '0;
            r_iter_cnt  <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shift[c] <= '0;
                r_match[c] <= '0;
            end
        end else if (w_start_run) begin
            r_zero_cnt  <= '0;
            r_align_cnt <= '0;
            r_bit_cnt   <= '0;
            r_iter_cnt  <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_match[c] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_ALIGN: begin
                    r_align_cnt <= r_align_cnt + AT_W'(1);
                    if (w_ch[0]) begin
                        r_zero_cnt <= '0;
                    end else begin
                        r_zero_cnt <= r_zero_cnt + ZR_W'(1);
                    end
                    if (w_aligned) begin
                        r_bit_cnt <= '0;
                    end
                    if (w_align_to) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_shift[c] <= {r_shift[c][PAT_W-2:0], w_ch[c]};
                    end
                end
                ST_COMPARE: begin
                    r_bit_cnt  <= '0;
                    r_iter_cnt <= r_iter_cnt + CNT_W'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (r_shift[c] == i_expected[c*PAT_W +: PAT_W] &&
                            r_match[c] != MAX_CNT) begin
                            r_match[c] <= r_match[c] + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            // Pass flag trails the count by one cycle and is sticky.
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_match[c] >= REQ_CNT) begin
                    r_result[c] <= 1'b1;
                end
            end
        end
    end

    assign o_busy          = is_busy(r_state);
    assign o_done          = (r_state == ST_DONE);
    assign o_timeout       = r_timeout;
    assign o_result_logged = r_result;

endmodule

// File: doc/multi_lane_clock_detector.md
MULTI_LANE_CLOCK_DETECTOR -- requirements
Module: multi_lane_clock_detector

Interface
REQ-001 Parameter NUM_CH, default 3, number of monitored channels (bit 0 = CKP, 1 = CKN, 2 = TRK).
REQ-002 Parameter PAT_W, default 48, compare-window width in bits.
REQ-003 Parameter ZERO_RUN, default 8, consecutive zeros on channel 0 required for alignment.
REQ-004 Parameter MAX_ITER, default 16, compare windows per run.
REQ-005 Parameter REQ_MATCH, default 16, matches per channel required for pass, 1..MAX_ITER.
REQ-006 Parameter ALIGN_TIMEOUT, default 1024, maximum ALIGN cycles before abort.
REQ-007 Port i_dig_clk, input, 1, the only clock.
REQ-008 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port i_ch, input, NUM_CH, asynchronous received clock/track lines.
REQ-010 Port i_expected, input, NUM_CH*PAT_W, per-channel expected window, quasi-static; channel c occupies bits [c*PAT_W +: PAT_W].
REQ-011 Port i_start, input, 1, run request, level-sampled.
REQ-012 Port i_clear_results, input, 1, synchronous abort and clear.
REQ-013 Port o_busy, output, 1, high in ALIGN, CAPTURE and COMPARE.
REQ-014 Port o_done, output, 1, high while in DONE.
REQ-015 Port o_timeout, output, 1, sticky: the last run aborted in ALIGN.
REQ-016 Port o_result_logged, output, NUM_CH, sticky per-channel pass flags.
REQ-017 Port o_match_cnt, output, NUM_CH*CNT_W, per-channel match counts, CNT_W = $clog2(MAX_ITER+1).

Function
REQ-018 Each i_ch bit passes through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-019 FSM states are IDLE, ALIGN, CAPTURE, COMPARE and DONE.
REQ-020 From IDLE or DONE, i_start moves the FSM to ALIGN next cycle and clears match counts, results, o_timeout and the iteration counter.
REQ-021 i_start is ignored in ALIGN, CAPTURE and COMPARE.
REQ-022 In ALIGN, a zero-run counter increments on a synchronized channel-0 zero and resets on a one; reaching ZERO_RUN moves the FSM to CAPTURE with the bit counter at 0.
REQ-023 ALIGN lasting ALIGN_TIMEOUT cycles moves the FSM to DONE and sets o_timeout; results stay 0.
REQ-024 In CAPTURE, every channel shifts its synchronized bit into a PAT_W-bit register, LSB first-in/MSB oldest, for exactly PAT_W cycles, then the FSM moves to COMPARE.
REQ-025 COMPARE lasts one cycle; its sample is discarded, so a frame is PAT_W+1 cycles.
REQ-026 In COMPARE, each channel whose shift register equals its i_expected slice increments its match count, saturating at MAX_ITER.
REQ-027 In COMPARE, the iteration counter increments; if it reaches MAX_ITER the FSM goes to DONE, otherwise to CAPTURE.
REQ-028 o_result_logged[c] is set on the cycle after o_match_cnt[c] reaches REQ_MATCH, and holds until start, clear or reset.
REQ-029 i_clear_results in any state returns the FSM to IDLE next cycle and clears all counters, shift registers, results and o_timeout.
REQ-030 i_clear_results has priority over i_start when both are asserted in the same cycle.
REQ-031 Alignment is not re-checked after CAPTURE begins; a slipped pattern only causes mismatches.

Reset
REQ-032 On i_rst_n low, the FSM goes to IDLE and all registers, including synchronizer flops, clear to 0; all outputs read 0.
REQ-033 Reset assertion mid-run aborts immediately; no result survives reset.

Structure
REQ-034 Package mb_clk_det_pkg holds the FSM state encodings and the default patterns CKP_PAT = 48'hAAAAAAAA0000, CKN_PAT = 48'h555555550000 and TRK_PAT = 48'hAAAAAAAA0000.
REQ-035 One sub-module, bit_synchronizer (2-flop, async active-low reset), is instantiated once per channel.

Verification
REQ-036 Defaults with golden CKP/CKN/TRK patterns after 8 zeros, start pulse: o_done after 16 frames of 49 cycles; o_match_cnt = 16,16,16; o_result_logged = 3'b111.
REQ-037 Channel 1 corrupted in frames 3 and 9: o_match_cnt[1] = 14 and o_result_logged = 3'b101.
REQ-038 Channel 0 stuck at 1: o_done and o_timeout after 1024 ALIGN cycles; results 3'b000.
REQ-039 i_clear_results during CAPTURE of frame 5: FSM in IDLE next cycle, with counts, o_busy and o_done all 0; a new start gives a full pass.
REQ-040 i_start and i_clear_results asserted together in IDLE: FSM stays IDLE; i_start pulsed during CAPTURE: no effect.
REQ-041 i_rst_n low in COMPARE: all outputs 0 asynchronously; NUM_CH = 5, PAT_W = 16 re-run of REQ-036 passes.
